// File: rtl/usrt_pkg.sv
// Shared UART definitions: divisor width, parity select codes and the
// transmitter state encoding.
package usrt_pkg;

  localparam int BAUD_W = 14;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_baudgen.sv
// Bit-period timer: counts 0..N-1 while enabled and pulses o_Bit_Tick on N-1.
// A divisor of zero behaves like one, so every enabled cycle ticks.
module uart_tx_baudgen #(
  parameter int BAUD_W = 14
) (
  input  logic              i_Pclk,
  input  logic              i_Reset_n,
  input  logic              i_En,
  input  logic [BAUD_W-1:0] i_N,
  output logic              o_Bit_Tick
);

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [BAUD_W-1:0] last;

  assign last       = (i_N == '0) ? '0 : i_N - BAUD_W'(1);
  assign o_Bit_Tick = i_En && (cnt_q == last);

  // Held at zero while disabled so each frame starts its first bit cleanly.
  always_comb begin
    cnt_d = cnt_q;
    if (!i_En || o_Bit_Tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + BAUD_W'(1);
    end
  end

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even/odd
// parity, one stop bit. Frame parameters are captured when the frame starts.
module uart_tx
  import usrt_pkg::*;
#(
  parameter int BAUD_W = usrt_pkg::BAUD_W
) (
  input  logic              i_Pclk,
  input  logic              i_Reset_n,
  input  logic              i_Start,
  input  logic [7:0]        i_Data,
  input  logic [BAUD_W-1:0] i_Baud,
  input  logic [1:0]        i_Parity,
  output logic              o_Tx_Serial,
  output logic              o_Tx_Busy,
  output logic              o_Tx_Done
);

  tx_state_e         state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [1:0]        parity_q, parity_d;
  logic [2:0]        idx_q, idx_d;
  logic              serial_q, serial_d;
  logic              done_q, done_d;

  logic       bit_tick;
  logic       tick_en;
  logic       parity_en;
  logic       parity_bit;
  logic [2:0] idx_next;

  assign tick_en    = (state_q != IDLE);
  assign parity_en  = (parity_q == PAR_EVEN) || (parity_q == PAR_ODD);
  assign parity_bit = (^data_q) ^ (parity_q == PAR_ODD);
  assign idx_next   = idx_q + 3'd1;

  uart_tx_baudgen #(
    .BAUD_W(BAUD_W)
  ) u_baudgen (
    .i_Pclk    (i_Pclk),
    .i_Reset_n (i_Reset_n),
    .i_En      (tick_en),
    .i_N       (baud_q),
    .o_Bit_Tick(bit_tick)
  );

  // The line value for the next bit is chosen on the transition into it,
  // so the serial output stays a plain register.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    baud_d   = baud_q;
    parity_d = parity_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (i_Start) begin
          data_d   = i_Data;
          baud_d   = i_Baud;
          parity_d = i_Parity;
          idx_d    = 3'd0;
          serial_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_tick) begin
          serial_d = data_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
            if (parity_en) begin
              serial_d = parity_bit;
              state_d  = PARITY;
            end else begin
              serial_d = 1'b1;
              state_d  = STOP;
            end
          end else begin
            idx_d    = idx_next;
            serial_d = data_q[idx_next];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          serial_d = 1'b1;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          serial_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        serial_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      baud_q   <= '0;
      parity_q <= PAR_NONE;
      idx_q    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      baud_q   <= baud_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Busy   = (state_q != IDLE);
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a monitor
// decodes the line cycle by cycle against a frame-level reference model.
module tb_uart_tx;

  typedef struct {
    logic [7:0] data;
    int         n;
    logic [1:0] par;
    bit         b2b;
  } frame_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [7:0]  data;
  logic [13:0] baud;
  logic [1:0]  parity;
  logic        o_Tx_Serial;
  logic        o_Tx_Busy;
  logic        o_Tx_Done;

  frame_t expQ[$];
  int     errors = 0;
  int     checks = 0;

  uart_tx dut (
    .i_Pclk     (clk),
    .i_Reset_n  (rstN),
    .i_Start    (start),
    .i_Data     (data),
    .i_Baud     (baud),
    .i_Parity   (parity),
    .o_Tx_Serial(o_Tx_Serial),
    .o_Tx_Busy  (o_Tx_Busy),
    .o_Tx_Done  (o_Tx_Done)
  );

  always #5 clk = ~clk;

  function automatic bit hasParity(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  function automatic int effN(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int frameBits(input frame_t f);
    return hasParity(f.par) ? 11 : 10;
  endfunction

  // Bit k of the frame on the wire: start, data LSB first, parity, stop.
  function automatic logic expBitAt(input frame_t f, input int k);
    int ones = 0;
    if (k == 0) return 1'b0;
    if (k <= 8) return f.data[k-1];
    if (k == 9 && hasParity(f.par)) begin
      for (int i = 0; i < 8; i++) ones += int'(f.data[i]);
      if (f.par == 2'b01) return (ones % 2) == 1;
      return (ones % 2) == 0;
    end
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic timeoutAbort(input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, busy=%0d done=%0d", what, o_Tx_Busy, o_Tx_Done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (o_Tx_Busy) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) timeoutAbort("waitIdle");
    end
  endtask

  // Issue one frame; returns #1 after the accepting edge (frame cycle 0).
  task automatic applyStimulus(input logic [7:0] d, input int n, input logic [1:0] p);
    frame_t f;
    waitIdle();
    data   = d;
    baud   = 14'(n);
    parity = p;
    start  = 1'b1;
    f = '{d, n, p, 1'b0};
    expQ.push_back(f);
    @(posedge clk); #1;
    start  = 1'b0;
    data   = 8'($urandom);
    baud   = 14'($urandom_range(0, 7));
    parity = 2'($urandom_range(0, 3));
  endtask

  task automatic pulseMidFrame(input int cycle, input logic [7:0] d);
    repeat (cycle) @(posedge clk);
    #1;
    data  = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Start held high through the done pulse of the first frame.
  task automatic sendPair(input logic [7:0] d1, input logic [7:0] d2, input int n,
                          input logic [1:0] p);
    frame_t f;
    int guard = 0;
    waitIdle();
    data   = d1;
    baud   = 14'(n);
    parity = p;
    start  = 1'b1;
    f = '{d1, n, p, 1'b0};
    expQ.push_back(f);
    @(posedge clk); #1;
    data = d2;
    f = '{d2, n, p, 1'b1};
    expQ.push_back(f);
    while (!o_Tx_Done) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) timeoutAbort("sendPairDone");
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin : monitor
    frame_t cur;
    bit     inFrame, doneNext, justDone, skipBusy, bitBad;
    int     cyc, len, nEff, frameNo, got, want, sample;
    inFrame  = 0;
    doneNext = 0;
    justDone = 0;
    skipBusy = 0;
    bitBad   = 0;
    frameNo  = 0;
    cyc      = 0;
    len      = 0;
    nEff     = 1;
    sample   = 0;
    forever begin
      @(negedge clk);
      got = int'({o_Tx_Busy, o_Tx_Done, o_Tx_Serial});
      if (!rstN) begin
        inFrame  = 0;
        doneNext = 0;
        justDone = 0;
        skipBusy = 0;
      end else if (doneNext) begin
        checkOutput($sformatf("frame%0d donePulse", frameNo), got, 3);
        doneNext = 0;
        justDone = 1;
      end else if (skipBusy) begin
        if (!o_Tx_Busy) skipBusy = 0;
        justDone = 0;
      end else begin
        if (!inFrame) begin
          if (o_Tx_Busy) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpectedFrame: busy=1 required=0 with no frame pending");
              skipBusy = 1;
            end else begin
              cur = expQ.pop_front();
              frameNo++;
              if (cur.b2b) checkOutput($sformatf("frame%0d backToBack", frameNo), int'(justDone), 1);
              nEff    = effN(cur.n);
              len     = frameBits(cur) * nEff;
              cyc     = 0;
              bitBad  = 0;
              inFrame = 1;
            end
          end else begin
            checkOutput("idleLine", got, 1);
          end
        end
        justDone = 0;
        if (inFrame) begin
          want = int'({1'b1, 1'b0, expBitAt(cur, cyc / nEff)});
          if (!bitBad) begin
            sample = got;
            if (got != want) bitBad = 1;
          end
          if ((cyc % nEff) == nEff - 1) begin
            checkOutput($sformatf("frame%0d bit%0d", frameNo, cyc / nEff), sample, want);
            bitBad = 0;
          end
          cyc++;
          if (cyc == len) begin
            inFrame  = 0;
            doneNext = 1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    int n, len, j;
    logic [1:0] p;
    rstN   = 1'b0;
    start  = 1'b0;
    data   = 8'h00;
    baud   = 14'd0;
    parity = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetSerial", int'(o_Tx_Serial), 1);
    checkOutput("resetBusy", int'(o_Tx_Busy), 0);
    checkOutput("resetDone", int'(o_Tx_Done), 0);
    #1 rstN = 1'b1;

    applyStimulus(8'hA5, 4, 2'b00);
    applyStimulus(8'hA5, 4, 2'b01);
    applyStimulus(8'hA5, 4, 2'b10);

    applyStimulus(8'hA5, 4, 2'b00);
    pulseMidFrame(9, 8'h3C);

    sendPair(8'h01, 8'hFF, 2, 2'b00);

    applyStimulus(8'h00, 0, 2'b00);

    applyStimulus(8'h5A, 4, 2'b00);
    repeat (17) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    checkOutput("abortSerial", int'(o_Tx_Serial), 1);
    checkOutput("abortBusy", int'(o_Tx_Busy), 0);
    checkOutput("abortDone", int'(o_Tx_Done), 0);
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    applyStimulus(8'hC3, 4, 2'b00);

    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 6);
      p = 2'($urandom_range(0, 3));
      applyStimulus(8'($urandom), n, p);
      if ($urandom_range(0, 1) == 1) begin
        len = (hasParity(p) ? 11 : 10) * effN(n);
        j = $urandom_range(1, len - 2);
        pulseMidFrame(j, 8'($urandom));
      end
      if (i % 8 == 7) sendPair(8'($urandom), 8'($urandom), $urandom_range(0, 3), p);
    end

    guard = 0;
    while (expQ.size() != 0 || o_Tx_Busy) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) timeoutAbort("drain");
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pendingFrames", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
